imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Purpose: shared types and constants for the instruction-memory loader.
//   Holds the FSM state encoding, the default memory geometry and the
//   header framing constants used by imem_loader and byte_packer.
package imem_loader_pkg;

    localparam int unsigned DEPTH_DEF  = 1024;
    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Purpose: assembles four accepted bytes, little-endian, into one 32-bit word.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   clr           - synchronous clear of the partial word
//   accept        - a byte is consumed this cycle
//   byte_in       - the byte being consumed
//   word_c        - assembled word, valid when word_ready_c is high
//   word_ready_c  - high in the cycle the 4th byte of a word is accepted
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready_c
);

    localparam int unsigned SH_W = WORD_W - BYTE_W;

    logic [1:0]      cnt;
    logic [SH_W-1:0] sh;

    // Byte counter and right-shifting holder for the first three bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            sh  <= '0;
        end else if (clr) begin
            cnt <= 2'd0;
            sh  <= '0;
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            sh  <= {byte_in, sh[SH_W-1:BYTE_W]};
        end
    end

    // The 4th byte bypasses the holder so the word is usable the same cycle
    assign word_c       = {byte_in, sh};
    assign word_ready_c = accept && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Purpose: loads a length-prefixed byte stream into instruction memory and
//   holds the CPU until a complete image has been written.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   start               - single-cycle request to begin a load session
//   rx_data, rx_valid   - incoming byte stream
//   rx_ready            - loader accepts a byte this cycle
//   we, waddr, wdata    - instruction memory write port
//   cpu_hold            - low only when a valid image is loaded
//   busy, done, err     - session status levels
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [WORD_W-1:0] wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state, state_nxt;
    logic                hdr_cnt, hdr_cnt_nxt;
    logic [BYTE_W-1:0]   hdr_lo, hdr_lo_nxt;
    logic [CNT_W-1:0]    n_words, n_words_nxt;
    logic [ADDR_W-1:0]   widx, widx_nxt;
    logic                we_nxt;
    logic [ADDR_W-1:0]   waddr_nxt;
    logic [WORD_W-1:0]   wdata_nxt;
    logic [CNT_W-1:0]    hdr_word;
    logic                xfer;
    logic                pk_accept;
    logic                pk_clr;
    logic [WORD_W-1:0]   pk_word_c;
    logic                pk_ready_c;

    assign xfer      = rx_valid && rx_ready;
    assign pk_accept = xfer && (state == ST_DATA);
    assign pk_clr    = (state == ST_HDR);

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (pk_clr),
        .accept       (pk_accept),
        .byte_in      (rx_data),
        .word_c       (pk_word_c),
        .word_ready_c (pk_ready_c)
    );

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        hdr_cnt_nxt = hdr_cnt;
        hdr_lo_nxt  = hdr_lo;
        n_words_nxt = n_words;
        widx_nxt    = widx;
        we_nxt      = 1'b0;
        waddr_nxt   = waddr;
        wdata_nxt   = wdata;
        hdr_word    = {rx_data, hdr_lo};

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt   = ST_HDR;
                    hdr_cnt_nxt = 1'b0;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    if (hdr_cnt == 1'(HDR_BYTES - 1)) begin
                        n_words_nxt = hdr_word;
                        widx_nxt    = '0;
                        if (hdr_word == '0)
                            state_nxt = ST_DONE;
                        else if (17'(hdr_word) > 17'(DEPTH))
                            state_nxt = ST_ERR;
                        else
                            state_nxt = ST_DATA;
                    end else begin
                        hdr_lo_nxt  = rx_data;
                        hdr_cnt_nxt = hdr_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (pk_ready_c) begin
                    state_nxt = ST_WRITE;
                    we_nxt    = 1'b1;
                    waddr_nxt = widx;
                    wdata_nxt = pk_word_c;
                end
            end
            ST_WRITE: begin
                // Index may wrap after the final word of a full-depth image; it is unused then
                widx_nxt  = widx + ADDR_W'(1);
                state_nxt = (CNT_W'(widx) == n_words - CNT_W'(1)) ? ST_DONE : ST_DATA;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; status levels follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hdr_cnt  <= 1'b0;
            hdr_lo   <= '0;
            n_words  <= '0;
            widx     <= '0;
            rx_ready <= 1'b0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            hdr_cnt  <= hdr_cnt_nxt;
            hdr_lo   <= hdr_lo_nxt;
            n_words  <= n_words_nxt;
            widx     <= widx_nxt;
            rx_ready <= (state_nxt == ST_HDR) || (state_nxt == ST_DATA);
            we       <= we_nxt;
            waddr    <= waddr_nxt;
            wdata    <= wdata_nxt;
            cpu_hold <= (state_nxt != ST_DONE);
            busy     <= (state_nxt == ST_HDR) || (state_nxt == ST_DATA) ||
                        (state_nxt == ST_WRITE);
            done     <= (state_nxt == ST_DONE);
            err      <= (state_nxt == ST_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose: directed self-checking bench for imem_loader.
module tb_imem_loader;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]       last_data = '0;
    logic              prev_we   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Write-port monitor: logs writes, checks single-cycle strobe and hold-when-idle
    always @(negedge clk) begin
        if (!rst_n) begin
            last_addr = '0;
            last_data = '0;
            prev_we   = 1'b0;
        end else if (we) begin
            chk("we_single_cycle", 32'(prev_we), 32'd0);
            wq_addr.push_back(waddr);
            wq_data.push_back(wdata);
            last_addr = waddr;
            last_data = wdata;
            prev_we   = 1'b1;
        end else begin
            chk("hold_waddr", 32'(waddr), 32'(last_addr));
            chk("hold_wdata", wdata, last_data);
            prev_we = 1'b0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer junk while not ready (must be ignored), then present b for one accepted cycle
    task automatic send_byte(input logic [7:0] b, input bit with_start, input int gap);
        int cnt;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        cnt = 0;
        while (!rx_ready && cnt < 64) begin
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
            @(negedge clk);
            cnt++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 32'd0, 32'd1);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = with_start;
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_end();
        int cnt;
        cnt = 0;
        while (!(done || err) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!(done || err)) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
    endtask

    logic [7:0]  bts[12];
    logic [31:0] img[DEPTH];

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_we",       32'(we),       32'd0);
        chk("rst_waddr",    32'(waddr),    32'd0);
        chk("rst_wdata",    wdata,         32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy",     32'(busy),     32'd0);
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);
        chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);

        // Three-word image, gap-free
        clear_log();
        pulse_start();
        chk("hdr_busy",     32'(busy),     32'd1);
        chk("hdr_rx_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h03, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        for (int i = 0; i < 12; i++) send_byte(8'(i), 1'b0, 0);
        wait_end();
        chk("n3_count", 32'(wq_addr.size()), 32'd3);
        if (wq_addr.size() == 3) begin
            chk("n3_a0", 32'(wq_addr[0]), 32'd0);
            chk("n3_d0", wq_data[0], 32'h03020100);
            chk("n3_a1", 32'(wq_addr[1]), 32'd1);
            chk("n3_d1", wq_data[1], 32'h07060504);
            chk("n3_a2", 32'(wq_addr[2]), 32'd2);
            chk("n3_d2", wq_data[2], 32'h0B0A0908);
        end
        chk("n3_done",     32'(done),     32'd1);
        chk("n3_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("n3_busy",     32'(busy),     32'd0);

        // Oversized header is rejected, then an empty image from ERR
        clear_log();
        pulse_start();
        chk("restart_done",     32'(done),     32'd0);
        chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("restart_busy",     32'(busy),     32'd1);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h04, 1'b0, 0);
        wait_end();
        chk("big_err",      32'(err),      32'd1);
        chk("big_busy",     32'(busy),     32'd0);
        chk("big_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("big_done",     32'(done),     32'd0);
        chk("big_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("big_no_we", 32'(wq_addr.size()), 32'd0);
        pulse_start();
        chk("err_restart_err",  32'(err),  32'd0);
        chk("err_restart_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        wait_end();
        chk("n0_done",     32'(done),     32'd1);
        chk("n0_err",      32'(err),      32'd0);
        chk("n0_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("n0_no_we",    32'(wq_addr.size()), 32'd0);

        // Random valid gaps with start pulses during DATA
        clear_log();
        for (int i = 0; i < 12; i++) bts[i] = 8'(8'h10 + 8'(i * 37));
        pulse_start();
        send_byte(8'h03, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        for (int i = 0; i < 12; i++)
            send_byte(bts[i], (i % 3) == 1, int'($urandom_range(0, 3)));
        wait_end();
        chk("gap_count", 32'(wq_addr.size()), 32'd3);
        if (wq_addr.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("gap_addr", 32'(wq_addr[k]), 32'(k));
                chk("gap_data", wq_data[k],
                    {bts[4*k+3], bts[4*k+2], bts[4*k+1], bts[4*k]});
            end
        end
        chk("gap_done", 32'(done), 32'd1);

        // Full-depth image
        clear_log();
        for (int i = 0; i < int'(DEPTH); i++) img[i] = $urandom;
        pulse_start();
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h04, 1'b0, 0);
        for (int i = 0; i < int'(DEPTH); i++)
            for (int j = 0; j < 4; j++) send_byte(img[i][8*j +: 8], 1'b0, 0);
        wait_end();
        chk("full_count", 32'(wq_addr.size()), 32'(DEPTH));
        chk("full_done",  32'(done), 32'd1);
        chk("full_err",   32'(err),  32'd0);
        if (wq_addr.size() == DEPTH) begin
            chk("full_last_addr", 32'(wq_addr[DEPTH-1]), 32'd1023);
            for (int i = 0; i < int'(DEPTH); i++) begin
                chk("full_addr", 32'(wq_addr[i]), 32'(i));
                chk("full_data", wq_data[i], img[i]);
            end
        end

        // Asynchronous reset mid-word, then a one-word session
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + 8'(i)), 1'b0, 0);
        chk("pre_rst_count", 32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() == 1) chk("pre_rst_d0", wq_data[0], 32'h43424140);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",     32'(busy),     32'd0);
        chk("arst_rx_ready", 32'(rx_ready), 32'd0);
        chk("arst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("arst_wdata",    wdata,         32'd0);
        chk("arst_waddr",    32'(waddr),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_no_we", 32'(wq_addr.size()), 32'd1);
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'hCC, 1'b0, 0);
        send_byte(8'hDD, 1'b0, 0);
        wait_end();
        chk("n1_count", 32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() == 1) begin
            chk("n1_addr", 32'(wq_addr[0]), 32'd0);
            chk("n1_data", wq_data[0], 32'hDDCCBBAA);
        end
        chk("n1_done", 32'(done), 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
